// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer bundle: received word, completion strobe, error flags and busy.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_byte;
  logic                 Rx_Done;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 busy;

  modport master (
    output data_byte,
    output Rx_Done,
    output parity_err,
    output frame_err,
    output break_det,
    output busy
  );

  modport slave (
    input data_byte,
    input Rx_Done,
    input parity_err,
    input frame_err,
    input break_det,
    input busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling, 6-sample majority per bit,
// runtime baud divisor / parity / stop bits, parity, framing and break reporting.
module uart_rx_param #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [DIV_W-1:0] bps_div,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  input  logic             Rs232_Rx,
  uart_rx_param_if.master  rx_if
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone} state_e;

  localparam logic [3:0] LastBit = 4'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  logic [DIV_W-1:0]     div_l_q, div_cnt_q;
  logic [1:0]           par_l_q;
  logic                 stop2_l_q;
  logic [3:0]           tick_cnt_q, bit_cnt_q;
  logic [2:0]           samp_cnt_q, samp_sum;
  logic [DATA_BITS-1:0] shreg_q, data_q;
  logic                 par_bit_q, ferr_acc_q, all_zero_q, stop_idx_q;
  logic                 done_q, perr_q, ferr_q, brk_q;

  logic start_edge, tick, at11, at15, in_win, bit_val, par_en;
  logic latch_cfg, shift_en, par_cap, stop_cap, stop_adv, bit_inc, bit_clr, finish;

  assign start_edge = rx_s3_q & ~rx_s2_q;
  assign tick       = (state_q != StIdle) && (div_cnt_q == div_l_q);
  assign at11       = tick && (tick_cnt_q == 4'd11);
  assign at15       = tick && (tick_cnt_q == 4'd15);
  assign in_win     = (tick_cnt_q >= 4'd6) && (tick_cnt_q <= 4'd11);
  // Count including the current sample, so the tick-11 decision sees all six votes
  assign samp_sum   = samp_cnt_q + {2'b00, rx_s2_q};
  assign bit_val    = (samp_sum >= 3'd4);
  assign par_en     = (par_l_q == 2'd1) || (par_l_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    latch_cfg = 1'b0;
    shift_en  = 1'b0;
    par_cap   = 1'b0;
    stop_cap  = 1'b0;
    stop_adv  = 1'b0;
    bit_inc   = 1'b0;
    bit_clr   = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d   = StStart;
          latch_cfg = 1'b1;
        end
      end
      StStart: begin
        if (at11 && (samp_sum > 3'd2)) state_d = StIdle;
        else if (at15)                 state_d = StData;
      end
      StData: begin
        if (at11) shift_en = 1'b1;
        if (at15) begin
          if (bit_cnt_q == LastBit) begin
            bit_clr = 1'b1;
            state_d = par_en ? StParity : StStop;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      StParity: begin
        if (at11) par_cap = 1'b1;
        if (at15) state_d = StStop;
      end
      StStop: begin
        // Leave right after the vote so an early next start edge is not missed
        if (at11) begin
          stop_cap = 1'b1;
          if (stop2_l_q && !stop_idx_q) begin
            stop_adv = 1'b1;
          end else begin
            finish  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= StIdle;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      div_l_q    <= '0;
      div_cnt_q  <= '0;
      par_l_q    <= 2'd0;
      stop2_l_q  <= 1'b0;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 4'd0;
      samp_cnt_q <= 3'd0;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      all_zero_q <= 1'b0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      rx_s1_q <= Rs232_Rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      state_q <= state_d;
      done_q  <= finish;

      if (latch_cfg) begin
        div_l_q    <= (bps_div == '0) ? DIV_W'(1) : bps_div;
        par_l_q    <= parity_mode;
        stop2_l_q  <= stop2;
        ferr_acc_q <= 1'b0;
        all_zero_q <= 1'b1;
        stop_idx_q <= 1'b0;
      end

      if (state_q == StIdle) begin
        div_cnt_q  <= '0;
        tick_cnt_q <= 4'd0;
        samp_cnt_q <= 3'd0;
        bit_cnt_q  <= 4'd0;
      end else if (tick) begin
        div_cnt_q  <= '0;
        tick_cnt_q <= tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd0) samp_cnt_q <= 3'd0;
        else if (in_win)        samp_cnt_q <= samp_sum;
      end else begin
        div_cnt_q <= div_cnt_q + DIV_W'(1);
      end

      if (bit_clr)      bit_cnt_q <= 4'd0;
      else if (bit_inc) bit_cnt_q <= bit_cnt_q + 4'd1;

      if (shift_en) begin
        shreg_q    <= {bit_val, shreg_q[DATA_BITS-1:1]};
        all_zero_q <= all_zero_q & ~bit_val;
      end else if (par_cap) begin
        par_bit_q  <= bit_val;
        all_zero_q <= all_zero_q & ~bit_val;
      end else if (stop_cap) begin
        ferr_acc_q <= ferr_acc_q | ~bit_val;
        all_zero_q <= all_zero_q & ~bit_val;
      end
      if (stop_adv) stop_idx_q <= 1'b1;

      if (finish) begin
        data_q <= shreg_q;
        ferr_q <= ferr_acc_q | ~bit_val;
        brk_q  <= all_zero_q & ~bit_val;
        perr_q <= par_en && ((^shreg_q ^ par_bit_q) != (par_l_q == 2'd2));
      end
    end
  end

  assign rx_if.data_byte  = data_q;
  assign rx_if.Rx_Done    = done_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.break_det  = brk_q;
  assign rx_if.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8-bit main instance plus 5- and 9-bit builds on their own lines.
module tb_uart_rx_param;

  logic        Clk;
  logic        Rst_n;
  logic [15:0] bps_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        rx8, rx5, rx9;

  uart_rx_param_if #(.DATA_BITS(8)) if8 ();
  uart_rx_param_if #(.DATA_BITS(5)) if5 ();
  uart_rx_param_if #(.DATA_BITS(9)) if9 ();

  uart_rx_param #(.DATA_BITS(8), .DIV_W(16)) dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .bps_div(bps_div), .parity_mode(parity_mode),
    .stop2(stop2), .Rs232_Rx(rx8), .rx_if(if8)
  );
  uart_rx_param #(.DATA_BITS(5), .DIV_W(16)) dut5 (
    .Clk(Clk), .Rst_n(Rst_n), .bps_div(bps_div), .parity_mode(parity_mode),
    .stop2(stop2), .Rs232_Rx(rx5), .rx_if(if5)
  );
  uart_rx_param #(.DATA_BITS(9), .DIV_W(16)) dut9 (
    .Clk(Clk), .Rst_n(Rst_n), .bps_div(bps_div), .parity_mode(parity_mode),
    .stop2(stop2), .Rs232_Rx(rx9), .rx_if(if9)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int done8 = 0, done5 = 0, done9 = 0;
  int exp8 = 0, exp5 = 0, exp9 = 0;
  logic [8:0] hist8[$];

  always @(negedge Clk) begin
    if (if8.Rx_Done) begin
      done8++;
      hist8.push_back({1'b0, if8.data_byte});
    end
    if (if5.Rx_Done) done5++;
    if (if9.Rx_Done) done9++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      5:       rx5 = v;
      9:       rx9 = v;
      default: rx8 = v;
    endcase
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge Clk);
  endtask

  function automatic int bclk(input int d);
    return ((d == 0) ? 2 : d + 1) * 16;
  endfunction

  // Start bit, data LSB first, optional parity bit, then nstop stop bits from stops[0] upward
  task automatic send_frame(input int which, input logic [8:0] d, input int nb, input bit pen,
                            input logic pb, input int nstop, input logic [1:0] stops,
                            input int bc);
    drive(which, 1'b0); hold(bc);
    for (int i = 0; i < nb; i++) begin
      drive(which, d[i]); hold(bc);
    end
    if (pen) begin
      drive(which, pb); hold(bc);
    end
    for (int i = 0; i < nstop; i++) begin
      drive(which, stops[i]); hold(bc);
    end
    drive(which, 1'b1);
  endtask

  initial begin
    Rst_n = 1'b0;
    rx8 = 1'b1; rx5 = 1'b1; rx9 = 1'b1;
    bps_div = 16'd26; parity_mode = 2'd0; stop2 = 1'b0;
    hold(5);
    Rst_n = 1'b1;
    hold(5);

    check("rst_data",  {8'h0, if8.data_byte}, 16'h0);
    check("rst_done",  {15'h0, if8.Rx_Done}, 16'h0);
    check("rst_flags", {13'h0, if8.parity_err, if8.frame_err, if8.break_det}, 16'h0);
    check("rst_busy",  {15'h0, if8.busy}, 16'h0);

    // 8N1 0xA5 at bps_div 26
    send_frame(8, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, bclk(26)); exp8++;
    hold(20);
    check("t1_count", 16'(done8), 16'(exp8));
    check("t1_data",  {8'h0, if8.data_byte}, 16'h00A5);
    check("t1_flags", {13'h0, if8.parity_err, if8.frame_err, if8.break_det}, 16'h0);
    check("t1_busy",  {15'h0, if8.busy}, 16'h0);

    // 8E1 0x37: correct parity bit is 1, then a wrong one
    bps_div = 16'd4; parity_mode = 2'd1;
    send_frame(8, 9'h037, 8, 1, 1'b1, 1, 2'b11, bclk(4)); exp8++;
    hold(20);
    check("t2a_count", 16'(done8), 16'(exp8));
    check("t2a_data",  {8'h0, if8.data_byte}, 16'h0037);
    check("t2a_perr",  {15'h0, if8.parity_err}, 16'h0);
    send_frame(8, 9'h037, 8, 1, 1'b0, 1, 2'b11, bclk(4)); exp8++;
    hold(20);
    check("t2b_count", 16'(done8), 16'(exp8));
    check("t2b_data",  {8'h0, if8.data_byte}, 16'h0037);
    check("t2b_perr",  {15'h0, if8.parity_err}, 16'h1);

    // 8N2 with the second stop bit low
    parity_mode = 2'd0; stop2 = 1'b1;
    send_frame(8, 9'h0C3, 8, 0, 1'b0, 2, 2'b01, bclk(4)); exp8++;
    hold(20);
    check("t3_count", 16'(done8), 16'(exp8));
    check("t3_data",  {8'h0, if8.data_byte}, 16'h00C3);
    check("t3_flags", {13'h0, if8.parity_err, if8.frame_err, if8.break_det}, 16'h2);

    // 100 ns glitch: false start, busy pulse only
    stop2 = 1'b0; bps_div = 16'd26;
    hold(40);
    rx8 = 1'b0; hold(5); rx8 = 1'b1;
    hold(5);
    check("t5_busy_hi", {15'h0, if8.busy}, 16'h1);
    hold(bclk(26));
    check("t5_busy_lo", {15'h0, if8.busy}, 16'h0);
    check("t5_count",   16'(done8), 16'(exp8));

    // Reset in the middle of the data bits, then a clean 0x5A
    rx8 = 1'b0; hold(bclk(26));
    rx8 = 1'b0; hold(bclk(26));
    rx8 = 1'b1; hold(bclk(26));
    rx8 = 1'b0; hold(bclk(26) / 2);
    check("t6_busy_mid", {15'h0, if8.busy}, 16'h1);
    Rst_n = 1'b0; rx8 = 1'b1;
    #1;
    check("t6_rst_data",  {8'h0, if8.data_byte}, 16'h0);
    check("t6_rst_flags", {12'h0, if8.Rx_Done, if8.parity_err, if8.frame_err, if8.break_det},
          16'h0);
    check("t6_rst_busy",  {15'h0, if8.busy}, 16'h0);
    hold(5);
    Rst_n = 1'b1;
    hold(2 * bclk(26));
    check("t6_abort_count", 16'(done8), 16'(exp8));
    send_frame(8, 9'h05A, 8, 0, 1'b0, 1, 2'b11, bclk(26)); exp8++;
    hold(20);
    check("t6_count", 16'(done8), 16'(exp8));
    check("t6_data",  {8'h0, if8.data_byte}, 16'h005A);

    // Line low for 12 bit times: break
    bps_div = 16'd4;
    rx8 = 1'b0; hold(12 * bclk(4)); exp8++;
    rx8 = 1'b1; hold(2 * bclk(4));
    check("t4_count", 16'(done8), 16'(exp8));
    check("t4_data",  {8'h0, if8.data_byte}, 16'h0);
    check("t4_flags", {13'h0, if8.parity_err, if8.frame_err, if8.break_det}, 16'h3);

    // Back-to-back frames, no idle gap
    send_frame(8, 9'h000, 8, 0, 1'b0, 1, 2'b11, bclk(4));
    send_frame(8, 9'h0FF, 8, 0, 1'b0, 1, 2'b11, bclk(4));
    send_frame(8, 9'h055, 8, 0, 1'b0, 1, 2'b11, bclk(4)); exp8 += 3;
    hold(20);
    check("t7_count", 16'(done8), 16'(exp8));
    if (hist8.size() >= 3) begin
      check("t7_w0", {7'h0, hist8[hist8.size()-3]}, 16'h0000);
      check("t7_w1", {7'h0, hist8[hist8.size()-2]}, 16'h00FF);
      check("t7_w2", {7'h0, hist8[hist8.size()-1]}, 16'h0055);
    end else begin
      tests++; fails++;
      $error("FAIL t7_hist: observed %0d words expected at least 3", hist8.size());
    end

    // 9-bit build: bps_div 0 (acts as 1), then 9E1 at bps_div 1
    bps_div = 16'd0;
    send_frame(9, 9'h1A5, 9, 0, 1'b0, 1, 2'b11, bclk(0)); exp9++;
    hold(10);
    check("w9a_count", 16'(done9), 16'(exp9));
    check("w9a_data",  {7'h0, if9.data_byte}, 16'h01A5);
    bps_div = 16'd1; parity_mode = 2'd1;
    send_frame(9, 9'h0B3, 9, 1, 1'b1, 1, 2'b11, bclk(1)); exp9++;
    hold(10);
    check("w9b_count", 16'(done9), 16'(exp9));
    check("w9b_data",  {7'h0, if9.data_byte}, 16'h00B3);
    check("w9b_perr",  {15'h0, if9.parity_err}, 16'h0);

    // 5-bit build at the slowest divisor
    bps_div = 16'd325; parity_mode = 2'd0;
    send_frame(5, 9'h015, 5, 0, 1'b0, 1, 2'b11, bclk(325)); exp5++;
    hold(20);
    check("w5_count", 16'(done5), 16'(exp5));
    check("w5_data",  {11'h0, if5.data_byte}, 16'h0015);
    check("w5_flags", {13'h0, if5.parity_err, if5.frame_err, if5.break_det}, 16'h0);
    check("idle8_count", 16'(done8), 16'(exp8));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
